alu_seq: RTL and testbench

//  Sequential, parametrised successor to the picoMIPS single-cycle ALU.
//  - Registers result and flags; flags persist as a V,N,Z,C flag register.
//  - Adds carry-chained ops (ADC/SBC) and a multi-cycle shift-add multiplier

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with registered result and V,N,Z,C flags, carry-chained ADC/SBC and a shift-add multiplier.
// Define ALU_SAT_EN to saturate signed overflow on add/subtract ops.
module alu_seq #(
  parameter int N    = 8,
  parameter int SW_W = 9
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [1:0]      a_sel,
  input  logic [1:0]      b_sel,
  input  logic [N-1:0]    a_in,
  input  logic [N-1:0]    b_in,
  input  logic [SW_W-1:0] switches,
  input  logic [N-1:0]    immediate,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    result,
  output logic [3:0]      flags
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] RA    = 3'b000;
  localparam logic [2:0] RB    = 3'b001;
  localparam logic [2:0] RADD  = 3'b010;
  localparam logic [2:0] RSUB  = 3'b011;
  localparam logic [2:0] RMULL = 3'b100;
  localparam logic [2:0] RMULH = 3'b101;
  localparam logic [2:0] RADC  = 3'b110;
  localparam logic [2:0] RSBC  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state, next_state;
  logic [N-1:0]   a_mux, b_mux;
  logic [N-1:0]   op_a, op_b;
  logic [2:0]     op_func;
  logic           cin_q;
  logic [2*N-1:0] prod;
  logic [CW-1:0]  cnt;
  logic [N:0]     step_sum;
  logic [N:0]     cin_ext, add_ext, sub_ext;
  logic [N-1:0]   raw, wr_result;
  logic           v_flag, c_flag;

  always_comb begin
    a_mux = a_in;
    b_mux = b_in;
    case (a_sel)
      2'b01:   a_mux = switches[N-1:0];
      2'b10:   a_mux = {N{switches[SW_W-1]}};
      default: a_mux = a_in;
    endcase
    case (b_sel)
      2'b01:   b_mux = switches[N-1:0];
      2'b10:   b_mux = {N{switches[SW_W-1]}};
      2'b11:   b_mux = immediate;
      default: b_mux = b_in;
    endcase
  end

  // Multiplier keeps the partial product in the high half and the unconsumed multiplier bits in the low half.
  assign step_sum = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, op_a} : '0);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (func[2:1] == 2'b10) ? MUL : DONE;
      MUL:     if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Only the carry-chained ops (bit 2 set, not a multiply) consume the latched carry/borrow.
  assign cin_ext = {{N{1'b0}}, op_func[2] & cin_q};
  assign add_ext = {1'b0, op_a} + {1'b0, op_b} + cin_ext;
  assign sub_ext = {1'b0, op_a} - {1'b0, op_b} - cin_ext;

  always_comb begin
    raw    = op_a;
    v_flag = 1'b0;
    c_flag = 1'b0;
    case (op_func)
      RA: raw = op_a;
      RB: raw = op_b;
      RADD, RADC: begin
        raw    = add_ext[N-1:0];
        c_flag = add_ext[N];
        v_flag = (op_a[N-1] == op_b[N-1]) && (raw[N-1] != op_a[N-1]);
      end
      RSUB, RSBC: begin
        raw    = sub_ext[N-1:0];
        c_flag = sub_ext[N];
        v_flag = (op_a[N-1] != op_b[N-1]) && (raw[N-1] != op_a[N-1]);
      end
      RMULL: begin
        raw    = prod[N-1:0];
        c_flag = |prod[2*N-1:N];
      end
      RMULH: begin
        raw    = prod[2*N-1:N];
        c_flag = |prod[2*N-1:N];
      end
      default: raw = op_a;
    endcase
    wr_result = raw;
`ifdef ALU_SAT_EN
    // On overflow the sign of a tells which way the true result ran off.
    if (v_flag) wr_result = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      result  <= '0;
      flags   <= '0;
      done    <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_func <= '0;
      cin_q   <= 1'b0;
      prod    <= '0;
      cnt     <= '0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= a_mux;
            op_b    <= b_mux;
            op_func <= func;
            cin_q   <= flags[0];
            prod    <= {{N{1'b0}}, b_mux};
            cnt     <= CW'(N - 1);
          end
        end
        MUL: begin
          prod <= {step_sum, prod[N-1:1]};
          cnt  <= cnt - 1'b1;
        end
        DONE: begin
          result <= wr_result;
          flags  <= {v_flag, wr_result[N-1], (wr_result == '0), c_flag};
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N=8, SW_W=9); expectations follow ALU_SAT_EN when defined.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start;
  logic [2:0] func;
  logic [1:0] a_sel, b_sel;
  logic [7:0] a_in, b_in, immediate;
  logic [8:0] switches;
  logic       busy, done;
  logic [7:0] result;
  logic [3:0] flags;

  int passed = 0;
  int total  = 0;

  alu_seq #(.N(8), .SW_W(9)) dut (
    .clk(clk), .nReset(nReset), .start(start), .func(func),
    .a_sel(a_sel), .b_sel(b_sel), .a_in(a_in), .b_in(b_in),
    .switches(switches), .immediate(immediate),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Launch one op and count falling edges until done shows; optional start pulses while busy.
  task automatic run_op(input logic [2:0] f, input logic [1:0] as, input logic [1:0] bs,
                        input logic [7:0] a, input logic [7:0] b, input logic [8:0] sw,
                        input logic [7:0] imm, input bit pulse, output int lat);
    @(negedge clk);
    func = f; a_sel = as; b_sel = bs; a_in = a; b_in = b; switches = sw; immediate = imm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      if (pulse && lat >= 1 && lat < 6) begin
        start = lat[0];
        func  = 3'b000;
        a_in  = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; start = 1'b0; func = 3'b000; a_sel = 2'b00; b_sel = 2'b00;
    a_in = 8'h00; b_in = 8'h00; switches = 9'h000; immediate = 8'h00;
    repeat (2) @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("[TB] FAIL reset_ctl got %b want 00", {busy, done}); else passed++;
    total++; if (result !== 8'h00) $display("[TB] FAIL reset_result got %h want 00", result); else passed++;
    total++; if (flags !== 4'b0000) $display("[TB] FAIL reset_flags got %b want 0000", flags); else passed++;
    nReset = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    logic [7:0] er;
    logic [3:0] ef;
`ifdef ALU_SAT_EN
    er = 8'h7F; ef = 4'b1000;
`else
    er = 8'h80; ef = 4'b1100;
`endif
    run_op(3'b010, 2'b00, 2'b00, 8'h7F, 8'h01, 9'h000, 8'h00, 1'b0, lat);
    total++; if (lat !== 1) $display("[TB] FAIL add_latency got %0d want 1", lat); else passed++;
    total++; if (result !== er) $display("[TB] FAIL add_result got %h want %h", result, er); else passed++;
    total++; if (flags !== ef) $display("[TB] FAIL add_flags got %b want %b", flags, ef); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL add_busy_at_done got %b want 0", busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("[TB] FAIL add_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_sub_sbc();
    int lat;
    run_op(3'b011, 2'b00, 2'b00, 8'h00, 8'h01, 9'h000, 8'h00, 1'b0, lat);
    total++; if (result !== 8'hFF) $display("[TB] FAIL sub_result got %h want ff", result); else passed++;
    total++; if (flags !== 4'b0101) $display("[TB] FAIL sub_flags got %b want 0101", flags); else passed++;
    run_op(3'b111, 2'b00, 2'b00, 8'h05, 8'h02, 9'h000, 8'h00, 1'b0, lat);
    total++; if (result !== 8'h02) $display("[TB] FAIL sbc_result got %h want 02", result); else passed++;
    total++; if (flags !== 4'b0000) $display("[TB] FAIL sbc_flags got %b want 0000", flags); else passed++;
  endtask

  task automatic test_mul();
    int lat;
    run_op(3'b101, 2'b00, 2'b00, 8'hFF, 8'hFF, 9'h000, 8'h00, 1'b1, lat);
    total++; if (lat !== 9) $display("[TB] FAIL mulh_latency got %0d want 9", lat); else passed++;
    total++; if (result !== 8'hFE) $display("[TB] FAIL mulh_result got %h want fe", result); else passed++;
    total++; if (flags !== 4'b0101) $display("[TB] FAIL mulh_flags got %b want 0101", flags); else passed++;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("[TB] FAIL mulh_no_queue got %b want 00", {busy, done}); else passed++;
    run_op(3'b100, 2'b00, 2'b00, 8'h0F, 8'h11, 9'h000, 8'h00, 1'b0, lat);
    total++; if (result !== 8'hFF) $display("[TB] FAIL mull_result got %h want ff", result); else passed++;
    total++; if (flags !== 4'b0100) $display("[TB] FAIL mull_flags got %b want 0100", flags); else passed++;
  endtask

  task automatic test_operand_select();
    int lat;
    run_op(3'b010, 2'b10, 2'b11, 8'h55, 8'h66, 9'h100, 8'h01, 1'b0, lat);
    total++; if (result !== 8'h00) $display("[TB] FAIL sel_result got %h want 00", result); else passed++;
    total++; if (flags !== 4'b0011) $display("[TB] FAIL sel_flags got %b want 0011", flags); else passed++;
    run_op(3'b001, 2'b00, 2'b01, 8'h00, 8'h00, 9'h0A5, 8'h00, 1'b0, lat);
    total++; if (result !== 8'hA5) $display("[TB] FAIL rb_switch_result got %h want a5", result); else passed++;
    total++; if (flags !== 4'b0100) $display("[TB] FAIL rb_switch_flags got %b want 0100", flags); else passed++;
  endtask

  task automatic test_back_to_back();
    logic expd;
    @(negedge clk);
    func = 3'b000; a_sel = 2'b00; b_sel = 2'b00; a_in = 8'h5A;
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      expd = (i % 2 == 0);
      total++; if (done !== expd) $display("[TB] FAIL b2b_done_%0d got %b want %b", i, done, expd); else passed++;
    end
    start = 1'b0;
    total++; if (result !== 8'h5A) $display("[TB] FAIL b2b_result got %h want 5a", result); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    func = 3'b100; a_sel = 2'b00; b_sel = 2'b00; a_in = 8'h0F; b_in = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) $display("[TB] FAIL midrst_busy_before got %b want 1", busy); else passed++;
    #2 nReset = 1'b0;
    #1;
    total++; if ({busy, done} !== 2'b00) $display("[TB] FAIL midrst_ctl got %b want 00", {busy, done}); else passed++;
    total++; if (result !== 8'h00) $display("[TB] FAIL midrst_result got %h want 00", result); else passed++;
    total++; if (flags !== 4'b0000) $display("[TB] FAIL midrst_flags got %b want 0000", flags); else passed++;
    @(negedge clk);
    nReset = 1'b1;
    run_op(3'b000, 2'b00, 2'b00, 8'h3C, 8'h00, 9'h000, 8'h00, 1'b0, lat);
    total++; if (lat !== 1) $display("[TB] FAIL post_rst_latency got %0d want 1", lat); else passed++;
    total++; if (result !== 8'h3C) $display("[TB] FAIL post_rst_result got %h want 3c", result); else passed++;
    total++; if (flags !== 4'b0000) $display("[TB] FAIL post_rst_flags got %b want 0000", flags); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbc();
    test_mul();
    test_operand_select();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
